imem_fetch_ctrl: RTL
====================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the fetch address width in bits.
REQ-002 Parameter ILEN, default 32, SHALL set the instruction word width in bits.
REQ-003 Parameter DEPTH, default 16, SHALL set the number of instruction words; legal range is 2..1024.
REQ-004 Parameter INIT, default all-zero DEPTH x ILEN array, SHALL set the contents loaded at reset; index 0 is the first element.
REQ-005 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-006 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-007 req_valid  input  1  SHALL indicate a fetch request.
REQ-008 req_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-009 req_addr  input  XLEN  SHALL carry the byte address of the fetch.
REQ-010 rsp_valid  output  1  SHALL indicate that a response is held.
REQ-011 rsp_ready  input  1  SHALL indicate that the consumer takes the response.
REQ-012 rsp_instr  output  ILEN  SHALL carry the fetched instruction.
REQ-013 rsp_fault  output  2  SHALL carry the fault code: 0 none, 1 misaligned, 2 out-of-range.
REQ-014 ld_en  input  1  SHALL be the write strobe of the program-load port.
REQ-015 ld_idx  input  $clog2(DEPTH)  SHALL carry the word index for a load.
REQ-016 ld_data  input  ILEN  SHALL carry the load data.
REQ-017 fetch_cnt  output  32  SHALL count accepted fetch requests.

Function
REQ-018 Response buffering SHALL use a two-state FSM. EMPTY moves to FULL on accept. FULL stays FULL on accept with rsp_ready. FULL moves to EMPTY on rsp_ready without accept.
REQ-019 req_ready SHALL equal (state==EMPTY) || rsp_ready, combinationally, with no dependence on req_valid.
REQ-020 A request SHALL be accepted when req_valid && req_ready, and its response SHALL appear with rsp_valid=1 on the next cycle (latency 1), giving one fetch per cycle at full throughput.
REQ-021 The word index SHALL be req_addr[$clog2(DEPTH)+1:2].
REQ-022 When req_addr[1:0]!=0, the response SHALL have rsp_fault=1 and rsp_instr=NOP (32'h00000013).
REQ-023 When the address is aligned and req_addr>>2 >= DEPTH, including any set upper bit, the response SHALL have rsp_fault=2 and rsp_instr=NOP.
REQ-024 Misalignment SHALL take priority over out-of-range.
REQ-025 While rsp_valid=1 && rsp_ready=0, rsp_instr and rsp_fault SHALL hold stable.
REQ-026 ld_en=1 SHALL write ld_data to word ld_idx at the clock edge; an ld_idx >= DEPTH SHALL be ignored.
REQ-027 When a load and an accepted fetch hit the same index in one cycle, the fetch SHALL return the pre-write data.
REQ-028 fetch_cnt SHALL increment by 1 per accepted request, including faulting requests, and SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-029 While rst_n=0 at a clock edge, state SHALL go to EMPTY, rsp_valid=0, rsp_instr=0, rsp_fault=0, fetch_cnt=0, and every word SHALL reload from INIT.
REQ-030 req_ready SHALL read 1 during and after reset.
REQ-031 A reset asserted while a response is pending SHALL discard that response, with no rsp_valid on the following cycle.
REQ-032 A reset SHALL take priority over ld_en.

Structure
REQ-033 Package imem_pkg SHALL hold the NOP constant, the 2-bit fault enum (FLT_NONE, FLT_MISALIGN, FLT_RANGE) and the FSM state enum.
REQ-034 Storage, the load port and the INIT reload SHALL sit in one sub-module, imem_array, with an asynchronous read and a synchronous write.
REQ-035 The FSM, fault decode and counter SHALL sit in imem_fetch_ctrl.

Verification
REQ-036 Setup: default INIT = {15,64,89,1,73,5,6,7,8,9,0...} for all scenarios.
REQ-037 Back-to-back fetch: fetch addr 0,4,8 on consecutive cycles with rsp_ready=1 -> rsp_instr 15,64,89 on cycles 1..3, req_ready stays 1, fetch_cnt=3.
REQ-038 Backpressure: fetch addr 12, rsp_ready=0 for 3 cycles -> rsp_instr=1 held stable and req_ready=0; after rsp_ready=1, the next fetch is accepted that cycle.
REQ-039 Faults: fetch addr 6 -> fault 1, instr 32'h13; fetch addr 64 (DEPTH=16) -> fault 2; fetch addr 2^40 -> fault 2; fetch_cnt increments for each.
REQ-040 Load collision: ld_en with idx 2, data 32'hDEADBEEF, and fetch addr 8 in the same cycle -> response 89; the next fetch of addr 8 -> 32'hDEADBEEF.
REQ-041 Reset mid-operation: pending response, then rst_n=0 for one cycle -> rsp_valid=0, fetch_cnt=0, and fetch addr 8 returns 89 (INIT restored).

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg
// Shared definitions for the instruction-memory fetch controller:
//   nop        - canonical RISC-V NOP (addi x0,x0,0) returned on faulting fetches
//   fault_e    - 2-bit fault code carried on rsp_fault
//   state_e    - response-buffer FSM state
package imem_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_RANGE    = 2'd2
    } fault_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/imem_array.sv
// imem_array
// Instruction word storage with a program-load write port and reload-from-INIT
// on reset. The read is asynchronous, so a fetch in the same cycle as a load to
// the same word sees the old contents; the write lands at the clock edge.
//   clk      - rising-edge clock
//   rst_n    - synchronous active-low reset, reloads every word from INIT
//   ld_en    - load write strobe (ignored while rst_n=0)
//   ld_idx   - load word index; indices >= DEPTH are dropped
//   ld_data  - load data
//   rd_idx   - asynchronous read word index
//   rd_data  - asynchronous read data
module imem_array #(
    parameter int ILEN  = 32,
    parameter int DEPTH = 16,
    parameter logic [ILEN-1:0] INIT [DEPTH] = '{default: '0},
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_idx,
    input  logic [ILEN-1:0] ld_data,
    input  logic [AW-1:0]   rd_idx,
    output logic [ILEN-1:0] rd_data
);

    logic [ILEN-1:0] mem [DEPTH];

    // Reset wins over a load in the same cycle. The index bound check only
    // matters when DEPTH is not a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT[i];
            end
        end else if (ld_en && (32'(ld_idx) < DEPTH)) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // Guard the read so an unused index above DEPTH never yields X.
    always_comb begin
        rd_data = '0;
        if (32'(rd_idx) < DEPTH) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Single-entry response-buffered instruction fetch unit. A request accepted in
// cycle N produces a response register visible in cycle N+1; with rsp_ready
// held high it sustains one fetch per cycle. Misaligned and out-of-range
// addresses return a NOP with a fault code instead of memory data.
//   clk, rst_n            - clock, synchronous active-low reset
//   req_valid/req_ready   - request handshake; req_addr is the byte address
//   rsp_valid/rsp_ready   - response handshake; rsp_instr / rsp_fault payload
//   ld_en/ld_idx/ld_data  - program-load write port into the storage array
//   fetch_cnt             - saturating count of accepted requests
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 16,
    parameter logic [ILEN-1:0] INIT [DEPTH] = '{default: '0}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [XLEN-1:0]          req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ILEN-1:0]          rsp_instr,
    output logic [1:0]               rsp_fault,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [ILEN-1:0]          ld_data,
    output logic [31:0]              fetch_cnt
);

    localparam int AW = $clog2(DEPTH);

    state_e          state, state_next;
    logic            accept;
    logic [AW-1:0]   word_idx;
    logic [ILEN-1:0] rd_data;
    fault_e          fault;
    logic [ILEN-1:0] instr_next;

    imem_array #(
        .ILEN  (ILEN),
        .DEPTH (DEPTH),
        .INIT  (INIT),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_en   (ld_en),
        .ld_idx  (ld_idx),
        .ld_data (ld_data),
        .rd_idx  (word_idx),
        .rd_data (rd_data)
    );

    // The buffer can take a new request when empty, or when the held response
    // leaves this same cycle.
    assign req_ready = (state == EMPTY) || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == FULL);
    assign word_idx  = req_addr[AW+1:2];

    // Misalignment is checked first so it wins over out-of-range. The range
    // check uses the whole shifted address so any set upper bit faults.
    always_comb begin
        fault      = FLT_NONE;
        instr_next = rd_data;
        if (req_addr[1:0] != 2'b00) begin
            fault      = FLT_MISALIGN;
            instr_next = ILEN'(NOP);
        end else if ((req_addr >> 2) >= XLEN'(DEPTH)) begin
            fault      = FLT_RANGE;
            instr_next = ILEN'(NOP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (rsp_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // The payload only changes on accept, which keeps it stable while a
    // response is stalled by rsp_ready=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_instr <= '0;
            rsp_fault <= 2'b00;
            fetch_cnt <= '0;
        end else if (accept) begin
            rsp_instr <= instr_next;
            rsp_fault <= fault;
            if (fetch_cnt != 32'hFFFF_FFFF) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule
